// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: computes the 64-bit result up front and
// commits it to HI/LO only after the architected busy latency has elapsed.
`timescale 1ns/1ps
module md_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_md,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [31:0] pend_hi, pend_lo;
   logic        pend_skip;

   logic        is_mul, is_div, is_signed, start_eff, div_zero;
   logic [63:0] mul_a, mul_b, product;
   logic [31:0] mag_a, mag_b, dvsr, q_mag, r_mag, quot, rem;
   logic [31:0] res_hi, res_lo;

   assign is_mul    = (md_op == 3'd1) || (md_op == 3'd2);
   assign is_div    = (md_op == 3'd3) || (md_op == 3'd4);
   assign is_signed = (md_op == 3'd1) || (md_op == 3'd3);
   assign start_eff = start && (state == IDLE) && (is_mul || is_div);
   assign div_zero  = (b == 32'd0);

   assign busy  = (state == RUN);
   assign stall = d_md && (start_eff || busy);

   // One 64x64 multiplier serves both flavours: the low 64 bits of the product of
   // sign-extended operands equal the signed 32x32 product.
   assign mul_a   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
   assign mul_b   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
   assign product = mul_a * mul_b;

   // Signed division runs on magnitudes, so 0x80000000 / -1 falls out as 0x80000000.
   assign mag_a = (is_signed && a[31]) ? -a : a;
   assign mag_b = (is_signed && b[31]) ? -b : b;
   assign dvsr  = div_zero ? 32'd1 : mag_b;
   assign q_mag = mag_a / dvsr;
   assign r_mag = mag_a % dvsr;
   assign quot  = (is_signed && (a[31] ^ b[31])) ? -q_mag : q_mag;
   assign rem   = (is_signed && a[31]) ? -r_mag : r_mag;

   assign res_hi = is_mul ? product[63:32] : rem;
   assign res_lo = is_mul ? product[31:0]  : quot;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_eff) state_nxt = RUN;
         RUN:     if (cnt == 4'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 4'd0;
         pend_hi   <= 32'd0;
         pend_lo   <= 32'd0;
         pend_skip <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
      end else if (state == IDLE) begin
         if (start_eff) begin
            pend_hi   <= res_hi;
            pend_lo   <= res_lo;
            pend_skip <= is_div && div_zero;
            cnt       <= is_mul ? MULT_LOAD : DIV_LOAD;
         end else if (start && (md_op == 3'd5)) begin
            hi <= a;
         end else if (start && (md_op == 3'd6)) begin
            lo <= a;
         end
      end else begin
         if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end else if (!pend_skip) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: each step drives a request and compares busy length,
// stall, and HI/LO against hand-computed values.
`timescale 1ns/1ps
module tb_md_sched;

   logic        clk = 1'b0;
   logic        rst, start, d_md;
   logic [2:0]  md_op;
   logic [31:0] a, b;
   logic        busy, stall;
   logic [31:0] hi, lo;

   int          tests  = 0;
   int          failed = 0;
   logic [31:0] m_hi   = 32'd0;
   logic [31:0] m_lo   = 32'd0;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .md_op (md_op),
      .a     (a),
      .b     (b),
      .d_md  (d_md),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo),
      .stall (stall)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one multi-cycle op; entered 1ns after a rising edge with the block idle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input int n_exp, input logic [31:0] e_hi,
                         input logic [31:0] e_lo, input bit inject);
      int n;
      int stall_n;
      bit hold_ok;
      start = 1'b1; md_op = op; a = va; b = vb;
      #1;
      check({tag, " stall_start"}, 32'(stall), 32'(d_md));
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      n = 0; stall_n = 0; hold_ok = 1'b1;
      while (busy === 1'b1 && n < 40) begin
         n++;
         if (stall === 1'b1) stall_n++;
         if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
         if (inject) begin
            start = (n == 2); md_op = 3'd1; a = 32'd100; b = 32'd100;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; md_op = 3'd0;
      check({tag, " busy_cycles"}, 32'(n), 32'(n_exp));
      check({tag, " stall_cycles"}, 32'(stall_n), d_md ? 32'(n_exp) : 32'd0);
      check({tag, " hold"}, 32'(hold_ok), 32'd1);
      check({tag, " hi"}, hi, e_hi);
      check({tag, " lo"}, lo, e_lo);
      check({tag, " stall_after"}, 32'(stall), 32'd0);
      m_hi = e_hi;
      m_lo = e_lo;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; d_md = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
      #12;
      check("reset busy", 32'(busy), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      d_md = 1'b1; #1;
      check("reset stall", 32'(stall), 32'd0);
      d_md = 1'b0;
      #3 rst = 1'b1;
      @(posedge clk); #1;

      // No-op code with start: no stall, no busy, HI/LO untouched.
      d_md = 1'b1; start = 1'b1; md_op = 3'd0; a = 32'h55;
      #1;
      check("noop stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("noop busy", 32'(busy), 32'd0);
      check("noop hi", hi, 32'd0);
      d_md = 1'b0;

      run_op("mult", 3'd1, 32'd3, 32'hFFFFFFFE, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
      run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);

      // mthi then mtlo on consecutive cycles.
      start = 1'b1; md_op = 3'd5; a = 32'h1234;
      @(posedge clk); #1;
      check("mthi hi", hi, 32'h1234);
      check("mthi busy", 32'(busy), 32'd0);
      md_op = 3'd6; a = 32'h5678;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      check("mtlo hi", hi, 32'h1234);
      check("mtlo lo", lo, 32'h5678);
      check("mtlo busy", 32'(busy), 32'd0);
      m_hi = 32'h1234; m_lo = 32'h5678;

      run_op("divu_zero", 3'd4, 32'd5, 32'd0, 10, 32'h1234, 32'h5678, 1'b0);

      d_md = 1'b1;
      run_op("multu_stall", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'd1, 32'hFFFFFFFE, 1'b0);
      d_md = 1'b0;

      run_op("mult_inject", 3'd1, 32'hFFFFFFFB, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b1);

      // Asynchronous reset in busy cycle 3 of a div.
      start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; md_op = 3'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_mid busy_before", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("rst_mid busy", 32'(busy), 32'd0);
      check("rst_mid hi", hi, 32'd0);
      check("rst_mid lo", lo, 32'd0);
      m_hi = 32'd0; m_lo = 32'd0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_release busy", 32'(busy), 32'd0);
      run_op("mult_after_rst", 3'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
